// File: rtl/svc_rv_pipe_stage.sv
// Generic valid/ready pipeline stage with skid buffer and flush-to-bubble (REG=1), or passthrough (REG=0).
// Optional statistics counters are built only when SVC_RV_PIPE_STATS_EN is defined.
module svc_rv_pipe_stage #(
  parameter int                    CTRL_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 128,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_DATA = '0,
  parameter int                    REG         = 1,
  parameter int                    STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CTRL_WIDTH-1:0] s_ctrl,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CTRL_WIDTH-1:0] m_ctrl,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [STAT_WIDTH-1:0] stall_cnt,
  output logic [STAT_WIDTH-1:0] flush_cnt
);

  if (REG != 0) begin : g_reg
    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                  accept;

    always_comb begin
      accept       = s_valid && !skid_valid_q;
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      if (!main_valid_q || m_ready) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = skid_ctrl_q;
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_valid_d = 1'b1;
          main_ctrl_d  = s_ctrl;
          main_data_d  = s_data;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        // Main is stalled: park the new entry so s_ready can stay a pure flop output.
        skid_valid_d = 1'b1;
        skid_ctrl_d  = s_ctrl;
        skid_data_d  = s_data;
      end
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
      end
    end

    // Payload is only observed through the valid-gated outputs, so it needs no reset.
    always_ff @(posedge clk) begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end

    assign s_ready = !skid_valid_q;
    assign m_valid = main_valid_q;
    assign m_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign m_data  = main_valid_q ? main_data_q : BUBBLE_DATA;
  end else begin : g_pass
    assign m_valid = s_valid && !flush;
    assign s_ready = m_ready || flush;
    assign m_ctrl  = m_valid ? s_ctrl : '0;
    assign m_data  = m_valid ? s_data : BUBBLE_DATA;
  end

`ifdef SVC_RV_PIPE_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                  held;

  always_comb begin
    // In the registered stage the skid slot is full exactly when s_ready is low.
    held        = (REG != 0) ? (m_valid || !s_ready) : 1'b0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (m_valid && !m_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
    if (flush && (held || (s_valid && s_ready)) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_svc_rv_pipe_stage.sv
// Directed bench for svc_rv_pipe_stage: a registered instance and a passthrough instance.
module tb_svc_rv_pipe_stage;
  localparam logic [31:0] BUB  = 32'hDEAD0013;
  localparam logic [31:0] PBUB = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0]  s_ctrl = '0;
  logic [31:0] s_data = '0;
  logic        s_ready, m_valid;
  logic [7:0]  m_ctrl, stall_cnt, flush_cnt;
  logic [31:0] m_data;

  logic        p_flush = 1'b0, p_s_valid = 1'b0, p_m_ready = 1'b0;
  logic [7:0]  p_s_ctrl = '0;
  logic [31:0] p_s_data = '0;
  logic        p_s_ready, p_m_valid;
  logic [7:0]  p_m_ctrl, p_stall_cnt, p_flush_cnt;
  logic [31:0] p_m_data;

  int checks = 0;
  int failures = 0;
  logic [41:0] got, exp;

  always #5 clk = ~clk;

  svc_rv_pipe_stage #(.CTRL_WIDTH(8), .DATA_WIDTH(32), .BUBBLE_DATA(BUB), .REG(1), .STAT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_ctrl(s_ctrl), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_ctrl(m_ctrl), .m_data(m_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  svc_rv_pipe_stage #(.CTRL_WIDTH(8), .DATA_WIDTH(32), .BUBBLE_DATA(PBUB), .REG(0), .STAT_WIDTH(8)) pdut (
    .clk(clk), .rst_n(rst_n), .flush(p_flush), .s_valid(p_s_valid), .s_ready(p_s_ready),
    .s_ctrl(p_s_ctrl), .s_data(p_s_data), .m_valid(p_m_valid), .m_ready(p_m_ready),
    .m_ctrl(p_m_ctrl), .m_data(p_m_data), .stall_cnt(p_stall_cnt), .flush_cnt(p_flush_cnt));

  function automatic logic [7:0] ctrl_of(input logic [31:0] d);
    return d[7:0] ^ 8'h5A;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    s_valid = v;
    s_data  = d;
    s_ctrl  = ctrl_of(d);
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    got = {m_valid, m_ctrl, m_data, s_ready};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 32'h0BAD0BAD; s_ctrl = 8'hFF; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; s_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    got = {m_valid, m_ctrl, m_data, s_ready};
    exp = {1'b0, 8'h00, BUB, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    checks++;
    if ({stall_cnt, flush_cnt} !== 16'h0000) begin
      failures++; $display("FAIL reset_counters got=%h exp=0000", {stall_cnt, flush_cnt});
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp = {1'b0, 8'h00, BUB, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_inputs_ignored got=%h exp=%h", got, exp); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      exp = (i == 1) ? {1'b0, 8'h00, BUB, 1'b1} : {1'b1, ctrl_of(32'(i - 1)), 32'(i - 1), 1'b1};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL stream_%0d got=%h exp=%h", i, got, exp); end
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp = {1'b1, ctrl_of(32'd8), 32'd8, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL stream_last got=%h exp=%h", got, exp); end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp = {1'b0, 8'h00, BUB, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL stream_drain got=%h exp=%h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic        mr [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic        rdy[11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [31:0] outq[$];
    int          nxt = 1;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      drive(nxt <= 6, 32'(nxt), mr[c], 1'b0);
      checks++;
      if (s_ready !== rdy[c]) begin
        failures++; $display("FAIL bp_s_ready_c%0d got=%b exp=%b", c, s_ready, rdy[c]);
      end
      if (m_valid && m_ready) outq.push_back(m_data);
      if (s_valid && s_ready) nxt++;
    end
    checks++;
    if (outq.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", outq.size()); end
    for (int k = 0; k < outq.size(); k++) begin
      checks++;
      if (outq[k] !== 32'(k + 1)) begin
        failures++; $display("FAIL bp_order_%0d got=%h exp=%h", k, outq[k], 32'(k + 1));
      end
    end
`ifdef SVC_RV_PIPE_STATS_EN
    exp = 42'd3;
`else
    exp = 42'd0;
`endif
    checks++;
    if (42'(stall_cnt) !== exp) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, exp); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 32'hA0A0A0A0, 1'b0, 1'b0);
    drive(1'b1, 32'hB0B0B0B0, 1'b0, 1'b0);
    drive(1'b1, 32'hC0C0C0C0, 1'b0, 1'b1);
    exp = {1'b1, ctrl_of(32'hA0A0A0A0), 32'hA0A0A0A0, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL flush_full got=%h exp=%h", got, exp); end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp = {1'b0, 8'h00, BUB, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL flush_bubble got=%h exp=%h", got, exp); end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_no_reappear_%0d got=%b exp=0", c, m_valid); end
    end
`ifdef SVC_RV_PIPE_STATS_EN
    exp = 42'd1;
`else
    exp = 42'd0;
`endif
    checks++;
    if (42'(flush_cnt) !== exp) begin failures++; $display("FAIL flush_cnt_1 got=%0d exp=%0d", flush_cnt, exp); end
    drive(1'b1, 32'hD0D0D0D0, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp = {1'b0, 8'h00, BUB, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL flush_accept got=%h exp=%h", got, exp); end
`ifdef SVC_RV_PIPE_STATS_EN
    exp = 42'd2;
`else
    exp = 42'd0;
`endif
    checks++;
    if (42'(flush_cnt) !== exp) begin failures++; $display("FAIL flush_cnt_2 got=%0d exp=%0d", flush_cnt, exp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 32'h11, 1'b1, 1'b0);
    drive(1'b1, 32'h22, 1'b1, 1'b0);
    exp = {1'b1, ctrl_of(32'h11), 32'h11, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    exp = {1'b1, ctrl_of(32'h22), 32'h22, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_no_bubble got=%h exp=%h", got, exp); end
    @(posedge clk);
    #1;
    s_valid = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    got = {m_valid, m_ctrl, m_data, s_ready};
    exp = {1'b1, ctrl_of(32'h22), 32'h22, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL b2b_skid_full got=%h exp=%h", got, exp); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    got = {m_valid, m_ctrl, m_data, s_ready};
    exp = {1'b0, 8'h00, BUB, 1'b1};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL midstall_reset got=%h exp=%h", got, exp); end
    checks++;
    if ({stall_cnt, flush_cnt} !== 16'h0000) begin
      failures++; $display("FAIL midstall_reset_cnt got=%h exp=0000", {stall_cnt, flush_cnt});
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL midstall_no_reappear got=%b exp=0", m_valid); end
  endtask

  task automatic test_passthrough();
    logic [41:0] pexp [5] = '{
      {1'b1, 8'h3C, 32'h12345678, 1'b0},
      {1'b1, 8'h3C, 32'h12345678, 1'b1},
      {1'b0, 8'h00, PBUB,         1'b1},
      {1'b0, 8'h00, PBUB,         1'b0},
      {1'b1, 8'h81, 32'hCAFEF00D, 1'b1}};
    logic [3:0] pin [5] = '{4'b1000, 4'b1010, 4'b1011, 4'b0000, 4'b1010};
    logic [31:0] pd [5] = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h0, 32'hCAFEF00D};
    logic [7:0]  pc [5] = '{8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h81};
    for (int v = 0; v < 5; v++) begin
      @(posedge clk);
      #1;
      p_s_valid = pin[v][3];
      p_m_ready = pin[v][1];
      p_flush   = pin[v][0];
      p_s_data  = pd[v];
      p_s_ctrl  = pc[v];
      #2;
      got = {p_m_valid, p_m_ctrl, p_m_data, p_s_ready};
      checks++;
      if (got !== pexp[v]) begin failures++; $display("FAIL pass_%0d got=%h exp=%h", v, got, pexp[v]); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
